// File: rtl/pcie_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pcie_reg_arbiter                                             |
// | Description : Serialises host and local reads/writes onto one single-port  |
// |               32-bit register file with per-requester read-data return.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pcie_reg_arbiter #(
    parameter int unsigned REG_ABITS = 3,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic                 pcieClk_in,
    input  logic                 reset_in,
    input  logic [REG_ABITS-1:0] hChan_in,
    input  logic [31:0]          hWrData_in,
    input  logic                 hWrValid_in,
    output logic                 hWrReady_out,
    input  logic                 hRdValid_in,
    output logic                 hRdReady_out,
    output logic [31:0]          hRdData_out,
    output logic                 hRdDataVld_out,
    input  logic [REG_ABITS-1:0] lChan_in,
    input  logic [31:0]          lWrData_in,
    input  logic                 lWrValid_in,
    output logic                 lWrReady_out,
    input  logic                 lRdValid_in,
    output logic                 lRdReady_out,
    output logic [31:0]          lRdData_out,
    output logic                 lRdDataVld_out,
    output logic [REG_ABITS-1:0] regChan_out,
    output logic [31:0]          regWrData_out,
    output logic                 regWrEn_out,
    input  logic [31:0]          regRdData_in
);

    typedef enum logic [0:0] {
        c_IDLE   = 1'b0,
        c_ACCESS = 1'b1
    } state_t;

    state_t                 r_state_q,     w_state_d;
    logic                   r_rr_h_q,      w_rr_h_d;
    logic                   r_gnt_h_q,     w_gnt_h_d;
    logic                   r_is_wr_q,     w_is_wr_d;
    logic [REG_ABITS-1:0]   r_chan_q,      w_chan_d;
    logic [31:0]            r_wdata_q,     w_wdata_d;
    logic [31:0]            r_h_rdata_q,   w_h_rdata_d;
    logic                   r_h_rvld_q,    w_h_rvld_d;
    logic [31:0]            r_l_rdata_q,   w_l_rdata_d;
    logic                   r_l_rvld_q,    w_l_rvld_d;

    logic w_h_act;
    logic w_l_act;
    logic w_pick_h;
    logic w_access_live;

    always_comb begin
        w_h_act     = hWrValid_in | hRdValid_in;
        w_l_act     = lWrValid_in | lRdValid_in;
        // r_rr_h_q set means H was not the last grantee
        w_pick_h    = w_h_act && (!w_l_act || FIXED_PRI || r_rr_h_q);

        w_state_d   = r_state_q;
        w_rr_h_d    = r_rr_h_q;
        w_gnt_h_d   = r_gnt_h_q;
        w_is_wr_d   = r_is_wr_q;
        w_chan_d    = r_chan_q;
        w_wdata_d   = r_wdata_q;
        w_h_rdata_d = r_h_rdata_q;
        w_h_rvld_d  = 1'b0;
        w_l_rdata_d = r_l_rdata_q;
        w_l_rvld_d  = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (w_h_act || w_l_act) begin
                    w_state_d = c_ACCESS;
                    w_gnt_h_d = w_pick_h;
                    w_rr_h_d  = !w_pick_h;
                    if (w_pick_h) begin
                        w_is_wr_d = hWrValid_in;
                        w_chan_d  = hChan_in;
                        w_wdata_d = hWrData_in;
                    end else begin
                        w_is_wr_d = lWrValid_in;
                        w_chan_d  = lChan_in;
                        w_wdata_d = lWrData_in;
                    end
                end
            end
            c_ACCESS: begin
                w_state_d = c_IDLE;
                if (!r_is_wr_q) begin
                    if (r_gnt_h_q) begin
                        w_h_rdata_d = regRdData_in;
                        w_h_rvld_d  = 1'b1;
                    end else begin
                        w_l_rdata_d = regRdData_in;
                        w_l_rvld_d  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            r_state_q   <= c_IDLE;
            r_rr_h_q    <= 1'b1;
            r_gnt_h_q   <= 1'b0;
            r_is_wr_q   <= 1'b0;
            r_chan_q    <= '0;
            r_wdata_q   <= '0;
            r_h_rdata_q <= '0;
            r_h_rvld_q  <= 1'b0;
            r_l_rdata_q <= '0;
            r_l_rvld_q  <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_rr_h_q    <= w_rr_h_d;
            r_gnt_h_q   <= w_gnt_h_d;
            r_is_wr_q   <= w_is_wr_d;
            r_chan_q    <= w_chan_d;
            r_wdata_q   <= w_wdata_d;
            r_h_rdata_q <= w_h_rdata_d;
            r_h_rvld_q  <= w_h_rvld_d;
            r_l_rdata_q <= w_l_rdata_d;
            r_l_rvld_q  <= w_l_rvld_d;
        end
    end

    // Reset arriving mid-access must suppress the strobe and handshakes this cycle
    assign w_access_live  = (r_state_q == c_ACCESS) && !reset_in;

    assign regChan_out    = r_chan_q;
    assign regWrData_out  = r_wdata_q;
    assign regWrEn_out    = w_access_live && r_is_wr_q;
    assign hWrReady_out   = w_access_live && r_is_wr_q && r_gnt_h_q;
    assign lWrReady_out   = w_access_live && r_is_wr_q && !r_gnt_h_q;
    assign hRdReady_out   = w_access_live && !r_is_wr_q && r_gnt_h_q;
    assign lRdReady_out   = w_access_live && !r_is_wr_q && !r_gnt_h_q;
    assign hRdData_out    = r_h_rdata_q;
    assign hRdDataVld_out = r_h_rvld_q;
    assign lRdData_out    = r_l_rdata_q;
    assign lRdDataVld_out = r_l_rvld_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pcie_reg_arbiter                                          |
// | Description : Directed self-checking bench; round-robin and fixed-priority |
// |               instances share stimulus, each with its own register model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pcie_reg_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic [2:0]  h_chan, l_chan;
    logic [31:0] h_wdata, l_wdata;
    logic        h_wr_vld, h_rd_vld_in, l_wr_vld, l_rd_vld_in;

    logic        h_wr_rdy, h_rd_rdy, h_rd_vld, l_wr_rdy, l_rd_rdy, l_rd_vld;
    logic [31:0] h_rd_data, l_rd_data, reg_wdata, reg_rdata;
    logic [2:0]  reg_chan;
    logic        reg_wen;

    logic        p_h_wr_rdy, p_h_rd_rdy, p_h_rd_vld, p_l_wr_rdy, p_l_rd_rdy, p_l_rd_vld;
    logic [31:0] p_h_rd_data, p_l_rd_data, p_reg_wdata, p_reg_rdata;
    logic [2:0]  p_reg_chan;
    logic        p_reg_wen;

    logic [31:0] mem0 [8];
    logic [31:0] mem1 [8];

    int checks   = 0;
    int failures = 0;

    pcie_reg_arbiter #(.REG_ABITS(3), .FIXED_PRI(1'b0)) u_rr (
        .pcieClk_in(clk), .reset_in(rst),
        .hChan_in(h_chan), .hWrData_in(h_wdata), .hWrValid_in(h_wr_vld), .hWrReady_out(h_wr_rdy),
        .hRdValid_in(h_rd_vld_in), .hRdReady_out(h_rd_rdy), .hRdData_out(h_rd_data), .hRdDataVld_out(h_rd_vld),
        .lChan_in(l_chan), .lWrData_in(l_wdata), .lWrValid_in(l_wr_vld), .lWrReady_out(l_wr_rdy),
        .lRdValid_in(l_rd_vld_in), .lRdReady_out(l_rd_rdy), .lRdData_out(l_rd_data), .lRdDataVld_out(l_rd_vld),
        .regChan_out(reg_chan), .regWrData_out(reg_wdata), .regWrEn_out(reg_wen), .regRdData_in(reg_rdata)
    );

    pcie_reg_arbiter #(.REG_ABITS(3), .FIXED_PRI(1'b1)) u_fp (
        .pcieClk_in(clk), .reset_in(rst),
        .hChan_in(h_chan), .hWrData_in(h_wdata), .hWrValid_in(h_wr_vld), .hWrReady_out(p_h_wr_rdy),
        .hRdValid_in(h_rd_vld_in), .hRdReady_out(p_h_rd_rdy), .hRdData_out(p_h_rd_data), .hRdDataVld_out(p_h_rd_vld),
        .lChan_in(l_chan), .lWrData_in(l_wdata), .lWrValid_in(l_wr_vld), .lWrReady_out(p_l_wr_rdy),
        .lRdValid_in(l_rd_vld_in), .lRdReady_out(p_l_rd_rdy), .lRdData_out(p_l_rd_data), .lRdDataVld_out(p_l_rd_vld),
        .regChan_out(p_reg_chan), .regWrData_out(p_reg_wdata), .regWrEn_out(p_reg_wen), .regRdData_in(p_reg_rdata)
    );

    assign reg_rdata   = mem0[reg_chan];
    assign p_reg_rdata = mem1[p_reg_chan];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file models; each entry starts at index * 0x11111111
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) begin
                mem0[i] <= 32'(i) * 32'h1111_1111;
                mem1[i] <= 32'(i) * 32'h1111_1111;
            end
        end else begin
            if (reg_wen)   mem0[reg_chan]   <= reg_wdata;
            if (p_reg_wen) mem1[p_reg_chan] <= p_reg_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        h_wr_vld    = 1'b0;
        h_rd_vld_in = 1'b0;
        l_wr_vld    = 1'b0;
        l_rd_vld_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        h_chan = '0; l_chan = '0; h_wdata = '0; l_wdata = '0;
        h_wr_vld = 1'b0; h_rd_vld_in = 1'b0; l_wr_vld = 1'b0; l_rd_vld_in = 1'b0;
        tick();
        mem_init = 1'b0;
        tick();

        chk("rst_wen",    32'(reg_wen),   0);
        chk("rst_hwrdy",  32'(h_wr_rdy),  0);
        chk("rst_chan",   32'(reg_chan),  0);
        chk("rst_wdata",  reg_wdata,      0);
        chk("rst_hrdata", h_rd_data,      0);
        chk("rst_hrvld",  32'(h_rd_vld),  0);
        chk("rst_lrdata", l_rd_data,      0);
        rst = 1'b0;

        // H write ch2
        h_chan = 3'd2; h_wdata = 32'hDEAD_BEEF; h_wr_vld = 1'b1;
        tick();
        chk("t1_wen",   32'(reg_wen),  1);
        chk("t1_chan",  32'(reg_chan), 2);
        chk("t1_wdata", reg_wdata,     32'hDEAD_BEEF);
        chk("t1_hwrdy", 32'(h_wr_rdy), 1);
        chk("t1_lwrdy", 32'(l_wr_rdy), 0);
        h_wr_vld = 1'b0;
        tick();
        chk("t1_wen_off",  32'(reg_wen),  0);
        chk("t1_hwrdy_off", 32'(h_wr_rdy), 0);
        chk("t1_mem2",     mem0[2],       32'hDEAD_BEEF);

        // H read ch2
        h_rd_vld_in = 1'b1;
        tick();
        chk("t2_hrdrdy", 32'(h_rd_rdy), 1);
        chk("t2_wen",    32'(reg_wen),  0);
        chk("t2_chan",   32'(reg_chan), 2);
        chk("t2_hrvld_early", 32'(h_rd_vld), 0);
        h_rd_vld_in = 1'b0;
        tick();
        chk("t2_hrvld",  32'(h_rd_vld), 1);
        chk("t2_hrdata", h_rd_data,     32'hDEAD_BEEF);
        chk("t2_hrdrdy_off", 32'(h_rd_rdy), 0);
        tick();
        chk("t2_hrvld_off", 32'(h_rd_vld), 0);
        chk("t2_hrdata_hold", h_rd_data,   32'hDEAD_BEEF);

        // Simultaneous writes to ch1 from reset: H then L
        do_reset();
        h_chan = 3'd1; h_wdata = 32'h11; h_wr_vld = 1'b1;
        l_chan = 3'd1; l_wdata = 32'h22; l_wr_vld = 1'b1;
        tick();
        chk("t3_hwrdy", 32'(h_wr_rdy), 1);
        chk("t3_lwrdy", 32'(l_wr_rdy), 0);
        chk("t3_wdata", reg_wdata,     32'h11);
        h_wr_vld = 1'b0;
        tick();
        chk("t3_idle_wen", 32'(reg_wen), 0);
        tick();
        chk("t3_lwrdy2", 32'(l_wr_rdy), 1);
        chk("t3_hwrdy2", 32'(h_wr_rdy), 0);
        chk("t3_wdata2", reg_wdata,     32'h22);
        l_wr_vld = 1'b0;
        tick();
        chk("t3_mem1", mem0[1], 32'h22);

        // Continuous read contention alternates H,L,H,L
        h_rd_vld_in = 1'b1; l_rd_vld_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_rr_h", 32'(h_rd_rdy), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_rr_l", 32'(l_rd_rdy), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        h_rd_vld_in = 1'b0; l_rd_vld_in = 1'b0;
        chk("t3_lrvld",  32'(l_rd_vld), 1);
        chk("t3_lrdata", l_rd_data,     32'h22);
        tick();

        // Fixed priority: H always wins until it drops
        do_reset();
        h_chan = 3'd0; l_chan = 3'd4;
        h_rd_vld_in = 1'b1; l_rd_vld_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_fp_h", 32'(p_h_rd_rdy), 1);
            chk("t4_fp_l", 32'(p_l_rd_rdy), 0);
            tick();
        end
        h_rd_vld_in = 1'b0;
        tick();
        chk("t4_fp_l_win", 32'(p_l_rd_rdy), 1);
        chk("t4_fp_h_off", 32'(p_h_rd_rdy), 0);
        l_rd_vld_in = 1'b0;
        tick();
        chk("t4_fp_lrdata", p_l_rd_data, 32'h4444_4444);

        // L write and read ch5 together: write first
        do_reset();
        l_chan = 3'd5; l_wdata = 32'h5; l_wr_vld = 1'b1; l_rd_vld_in = 1'b1;
        tick();
        chk("t5_lwrdy", 32'(l_wr_rdy), 1);
        chk("t5_lrdrdy", 32'(l_rd_rdy), 0);
        chk("t5_wen",   32'(reg_wen),  1);
        l_wr_vld = 1'b0;
        tick();
        chk("t5_idle_rdy", 32'(l_rd_rdy), 0);
        tick();
        chk("t5_lrdrdy2", 32'(l_rd_rdy), 1);
        chk("t5_wen2",    32'(reg_wen),  0);
        chk("t5_chan",    32'(reg_chan), 5);
        l_rd_vld_in = 1'b0;
        tick();
        chk("t5_lrvld",  32'(l_rd_vld), 1);
        chk("t5_lrdata", l_rd_data,     32'h5);
        chk("t5_hrvld",  32'(h_rd_vld), 0);

        // Reset during ACCESS of H write ch3
        do_reset();
        h_chan = 3'd3; h_wdata = 32'h77; h_wr_vld = 1'b1;
        tick();
        chk("t6_pre_hwrdy", 32'(h_wr_rdy), 1);
        rst = 1'b1;
        #1;
        chk("t6_wen_gated",   32'(reg_wen),  0);
        chk("t6_hwrdy_gated", 32'(h_wr_rdy), 0);
        h_wr_vld = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6_mem3", mem0[3], 32'h3333_3333);
        chk("t6_hrvld", 32'(h_rd_vld), 0);
        h_rd_vld_in = 1'b1;
        tick();
        chk("t6_idle_then_rdy", 32'(h_rd_rdy), 1);
        chk("t6_wen_after",     32'(reg_wen),  0);
        h_rd_vld_in = 1'b0;
        tick();
        chk("t6_hrvld2",  32'(h_rd_vld), 1);
        chk("t6_hrdata",  h_rd_data,     32'h3333_3333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
